// File: rtl/imem_loader_pkg.sv
// imem_pkg: shared types and geometry for the input-memory loader.
// Provides the loader state enum and the fixed geometry of the 128 x 4-bit
// input memory: total nibbles, nibbles per bank, bank count and bus widths.
package imem_pkg;

   localparam int NUM_NIB      = 128;
   localparam int NIB_PER_BANK = 32;
   localparam int NUM_BANK     = NUM_NIB / NIB_PER_BANK;
   localparam int NIB_W        = 4;
   localparam int BYTE_W       = 8;
   localparam int ADDR_W       = $clog2(NUM_NIB);
   localparam int BANK_W       = $clog2(NUM_BANK);
   localparam int BANK_BITS    = NIB_PER_BANK * NIB_W;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD_LO = 3'd1,
      ST_LOAD_HI = 3'd2,
      ST_FULL    = 3'd3,
      ST_FETCH   = 3'd4
   } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus memory write/read control bundle.
//   in_data/in_valid/in_ready : byte source handshake
//   iaddr/idata/wr            : memory write port (nibble granularity)
//   oaddr/rd                  : memory read port (bank granularity)
//   bank_valid/bank_idx       : marks the bank currently on the memory output
// Modports: loader (the sequencer), env (byte source + memory side).
interface imem_loader_if;
   import imem_pkg::*;

   logic [BYTE_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] iaddr;
   logic [NIB_W-1:0]  idata;
   logic              wr;
   logic [BANK_W-1:0] oaddr;
   logic              rd;
   logic              bank_valid;
   logic [BANK_W-1:0] bank_idx;

   modport loader (
      input  in_data, in_valid,
      output in_ready, iaddr, idata, wr, oaddr, rd, bank_valid, bank_idx
   );

   modport env (
      output in_data, in_valid,
      input  in_ready, iaddr, idata, wr, oaddr, rd, bank_valid, bank_idx
   );

endinterface

// File: rtl/imem_loader.sv
// imem_loader: front-end sequencer for the 128 x 4-bit input memory.
// Splits accepted bytes into nibbles (low first), writes them to ascending
// nibble addresses 0..127, then on fetch reads the four banks back in order.
// Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   start         : pulse, begin a new load (accepted in IDLE and FULL)
//   fetch         : pulse, read out all banks (accepted in FULL)
//   busy          : high while loading or fetching
//   load_done     : one-cycle pulse the cycle after the write to nibble 127
//   bus           : handshake and memory control (imem_loader_if.loader)
// All outputs are registered.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start, memory contents undefined
// ST_LOAD_LO | in_ready high, waiting for a byte; shows previous high write
// ST_LOAD_HI | low nibble write on the bus; high nibble issued next
// ST_FULL    | memory loaded, waiting for fetch or a reload start
// ST_FETCH   | rd issued for banks 0..3 on consecutive cycles
module imem_loader
   import imem_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic start,
   input  logic fetch,
   output logic busy,
   output logic load_done,
   imem_loader_if.loader bus
);

   localparam logic [ADDR_W-1:0] LAST_NIB  = ADDR_W'(NUM_NIB - 1);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANK - 1);

   state_e            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [NIB_W-1:0]  pend_q;
   logic              in_ready_q;
   logic              busy_q;
   logic              load_done_q;
   logic [ADDR_W-1:0] iaddr_q;
   logic [NIB_W-1:0]  idata_q;
   logic              wr_q;
   logic [BANK_W-1:0] oaddr_q;
   logic              rd_q;
   logic              bank_valid_q;
   logic [BANK_W-1:0] bank_idx_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         pend_q       <= '0;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         load_done_q  <= 1'b0;
         iaddr_q      <= '0;
         idata_q      <= '0;
         wr_q         <= 1'b0;
         oaddr_q      <= '0;
         rd_q         <= 1'b0;
         bank_valid_q <= 1'b0;
         bank_idx_q   <= '0;
      end else begin
         wr_q         <= 1'b0;
         rd_q         <= 1'b0;
         // memory returns data one cycle after rd
         bank_valid_q <= rd_q;
         if (rd_q) begin
            bank_idx_q <= oaddr_q;
         end
         load_done_q  <= wr_q && (iaddr_q == LAST_NIB);

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_LOAD_LO;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end

            ST_LOAD_LO: begin
               if (bus.in_valid && in_ready_q) begin
                  wr_q       <= 1'b1;
                  iaddr_q    <= cnt_q;
                  idata_q    <= bus.in_data[NIB_W-1:0];
                  pend_q     <= bus.in_data[BYTE_W-1:NIB_W];
                  in_ready_q <= 1'b0;
                  state_q    <= ST_LOAD_HI;
               end
            end

            ST_LOAD_HI: begin
               wr_q    <= 1'b1;
               iaddr_q <= cnt_q + ADDR_W'(1);
               idata_q <= pend_q;
               cnt_q   <= cnt_q + ADDR_W'(2);
               if (cnt_q + ADDR_W'(1) == LAST_NIB) begin
                  // busy stays up while the final write is on the bus
                  state_q <= ST_FULL;
               end else begin
                  in_ready_q <= 1'b1;
                  state_q    <= ST_LOAD_LO;
               end
            end

            ST_FULL: begin
               busy_q <= 1'b0;
               // the first FULL cycle still shows the final write; commands
               // are taken once that write has left the bus
               if (!wr_q) begin
                  if (start) begin
                     state_q    <= ST_LOAD_LO;
                     cnt_q      <= '0;
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b1;
                  end else if (fetch) begin
                     state_q <= ST_FETCH;
                     rd_q    <= 1'b1;
                     oaddr_q <= '0;
                     busy_q  <= 1'b1;
                  end
               end
            end

            ST_FETCH: begin
               if (oaddr_q == LAST_BANK) begin
                  state_q <= ST_FULL;
                  busy_q  <= 1'b0;
               end else begin
                  rd_q    <= 1'b1;
                  oaddr_q <= oaddr_q + BANK_W'(1);
               end
            end

            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign busy           = busy_q;
   assign load_done      = load_done_q;
   assign bus.in_ready   = in_ready_q;
   assign bus.iaddr      = iaddr_q;
   assign bus.idata      = idata_q;
   assign bus.wr         = wr_q;
   assign bus.oaddr      = oaddr_q;
   assign bus.rd         = rd_q;
   assign bus.bank_valid = bank_valid_q;
   assign bus.bank_idx   = bank_idx_q;

endmodule
